// File: rtl/cdr_pkg.sv
// -----------------------------------------------------------------------------
// cdr_pkg
// Types and constants shared by the CDR front-end blocks (period estimator and
// sample-point counter).
//   cdr_state_t : acquisition state of the period estimator
//   CDR_P_W     : width of the chip-period bus between the stages
// -----------------------------------------------------------------------------
package cdr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2
    } cdr_state_t;

    localparam int CDR_P_W = 6;

endpackage : cdr_pkg

// File: rtl/cdr_edge_detect.sv
// -----------------------------------------------------------------------------
// cdr_edge_detect
// Transition detector on the sliced chip stream. Remembers the previous valid
// sample and flags a data transition on the current valid sample. The detector
// is "primed" only once a sample has been loaded, so the first sample after
// reset or after a clear can never look like an edge.
// Ports:
//   clk_i   : clock
//   rst_i   : synchronous reset, active-high
//   valid_i : sample strobe; state advances only when high
//   data_i  : sliced chip sample
//   clr_i   : forget the stored sample (drop primed) on this cycle
//   edge_o  : combinational, high when valid_i and data_i differs from the
//             previous stored sample
// -----------------------------------------------------------------------------
module cdr_edge_detect (
    input  logic clk_i,
    input  logic rst_i,
    input  logic valid_i,
    input  logic data_i,
    input  logic clr_i,
    output logic edge_o
);

    logic d_q;
    logic d_d;
    logic primed_q;
    logic primed_d;

    // Next-state for the stored sample and primed flag
    always_comb begin
        d_d      = d_q;
        primed_d = primed_q;
        if (valid_i) begin
            d_d      = data_i;
            primed_d = ~clr_i;
        end else if (clr_i) begin
            primed_d = 1'b0;
        end else begin
            primed_d = primed_q;
        end
    end

    // Stored-sample registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            d_q      <= 1'b0;
            primed_q <= 1'b0;
        end else begin
            d_q      <= d_d;
            primed_q <= primed_d;
        end
    end

    assign edge_o = valid_i & primed_q & (data_i != d_q);

endmodule : cdr_edge_detect

// File: rtl/cdr_period_estimator.sv
// -----------------------------------------------------------------------------
// cdr_period_estimator
// Measures the sample count between transitions of the sliced chip stream and
// estimates the chip period as the minimum interval over a window of N_EDGES
// accepted edges. The estimate is trusted (o_lock) once a window has been
// collected, and stays trusted while successive window minima stay within TOL
// of the current estimate.
//
// Optional build macro: CDR_PERIOD_SMOOTH_EN
//   defined   : a within-tolerance window end in LOCK averages the new minimum
//               into the estimate, rounding up.
//   undefined : the new minimum replaces the estimate directly.
//
// Ports:
//   i_clk   : clock
//   i_rst   : synchronous reset, active-high
//   i_valid : sample strobe; all state advances only when high
//   i_data  : sliced chip sample (sign bit)
//   o_nb_P  : estimated chip period in samples (registered)
//   o_lock  : estimate valid, enables the sample-point counter (registered)
//   o_edge  : one-cycle pulse per accepted edge (registered)
// -----------------------------------------------------------------------------
module cdr_period_estimator
    import cdr_pkg::*;
#(
    parameter int W         = CDR_P_W,
    parameter int MIN_P     = 4,
    parameter int N_EDGES   = 8,
    parameter int TOL       = 1,
    parameter int DEFAULT_P = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    input  logic         i_data,
    output logic [W-1:0] o_nb_P,
    output logic         o_lock,
    output logic         o_edge
);

    localparam int ECNT_W = $clog2(N_EDGES + 1);

    localparam logic [W-1:0]      CNT_MAX   = {W{1'b1}};
    localparam logic [W-1:0]      ONE_W     = W'(1);
    localparam logic [W-1:0]      MIN_P_W   = W'(MIN_P);
    localparam logic [W-1:0]      TOL_W     = W'(TOL);
    localparam logic [W-1:0]      DEF_P_W   = W'(DEFAULT_P);
    localparam logic [ECNT_W-1:0] N_EDGE_E  = ECNT_W'(N_EDGES);
    localparam logic [ECNT_W-1:0] ECNT_ZERO = {ECNT_W{1'b0}};
    localparam logic [ECNT_W-1:0] ECNT_ONE  = ECNT_W'(1);

    cdr_state_t        state_q;
    cdr_state_t        state_d;
    logic [W-1:0]      cnt_q;
    logic [W-1:0]      cnt_d;
    logic [ECNT_W-1:0] ecnt_q;
    logic [ECNT_W-1:0] ecnt_d;
    logic [W-1:0]      win_min_q;
    logic [W-1:0]      win_min_d;
    logic [W-1:0]      nb_p_q;
    logic [W-1:0]      nb_p_d;
    logic              lock_q;
    logic              lock_d;
    logic              edge_q;
    logic              edge_d;

    logic              raw_edge_s;
    logic              clr_s;
    logic              in_win_s;
    logic              accept_s;
    logic [W-1:0]      cnt_inc_s;
    logic [W-1:0]      new_min_s;
    logic [ECNT_W-1:0] ecnt_inc_s;
    logic [W-1:0]      abs_diff_s;
    logic              within_tol_s;

    cdr_edge_detect u_edge (
        .clk_i   (i_clk),
        .rst_i   (i_rst),
        .valid_i (i_valid),
        .data_i  (i_data),
        .clr_i   (clr_s),
        .edge_o  (raw_edge_s)
    );

    // Datapath helpers: acceptance, saturating count, window minimum, tolerance
    always_comb begin
        in_win_s     = (state_q != IDLE);
        // Short intervals are glitches only once a window is running; the
        // start edge in IDLE is always taken.
        accept_s     = raw_edge_s & (~in_win_s | (cnt_q >= MIN_P_W));
        cnt_inc_s    = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + ONE_W);
        new_min_s    = (cnt_q < win_min_q) ? cnt_q : win_min_q;
        ecnt_inc_s   = ecnt_q + ECNT_ONE;
        abs_diff_s   = (new_min_s > nb_p_q) ? (new_min_s - nb_p_q) : (nb_p_q - new_min_s);
        within_tol_s = (abs_diff_s <= TOL_W);
    end

    // Next-state and output logic of the acquisition FSM
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ecnt_d    = ecnt_q;
        win_min_d = win_min_q;
        nb_p_d    = nb_p_q;
        lock_d    = lock_q;
        edge_d    = 1'b0;
        clr_s     = 1'b0;

        if (i_valid) begin
            if (accept_s) begin
                edge_d = 1'b1;
                cnt_d  = ONE_W;
                case (state_q)
                    IDLE: begin
                        // Start edge: opens a window, no interval yet.
                        state_d   = ACQ;
                        ecnt_d    = ECNT_ZERO;
                        win_min_d = CNT_MAX;
                    end
                    ACQ, LOCK: begin
                        if (ecnt_inc_s == N_EDGE_E) begin
                            ecnt_d    = ECNT_ZERO;
                            win_min_d = CNT_MAX;
                            if (state_q == ACQ) begin
                                nb_p_d  = new_min_s;
                                lock_d  = 1'b1;
                                state_d = LOCK;
                            end else if (within_tol_s) begin
`ifdef CDR_PERIOD_SMOOTH_EN
                                // Average in W+1 bits with round-up.
                                nb_p_d = W'(({1'b0, nb_p_q} + {1'b0, new_min_s} + (W+1)'(1)) >> 1);
`else
                                nb_p_d = new_min_s;
`endif
                            end else begin
                                lock_d  = 1'b0;
                                state_d = ACQ;
                            end
                        end else begin
                            ecnt_d    = ecnt_inc_s;
                            win_min_d = new_min_s;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        lock_d  = 1'b0;
                        clr_s   = 1'b1;
                    end
                endcase
            end else begin
                // No accepted edge (none, or a rejected glitch): keep counting.
                cnt_d = cnt_inc_s;
                if (in_win_s && (cnt_inc_s == CNT_MAX)) begin
                    // Line went quiet: drop lock, keep the last estimate.
                    state_d = IDLE;
                    lock_d  = 1'b0;
                    clr_s   = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
        end else begin
            edge_d = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            cnt_q     <= {W{1'b0}};
            ecnt_q    <= ECNT_ZERO;
            win_min_q <= CNT_MAX;
            nb_p_q    <= DEF_P_W;
            lock_q    <= 1'b0;
            edge_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ecnt_q    <= ecnt_d;
            win_min_q <= win_min_d;
            nb_p_q    <= nb_p_d;
            lock_q    <= lock_d;
            edge_q    <= edge_d;
        end
    end

    assign o_nb_P = nb_p_q;
    assign o_lock = lock_q;
    assign o_edge = edge_q;

endmodule : cdr_period_estimator

// File: doc/cdr_period_estimator.md
Name: cdr_period_estimator

Overview:
- Upstream stage of the CDR sample-point counter.
- Watches the sliced (hard-decision) demodulator chip stream, measures the sample count between data transitions and estimates the chip period in samples.
- Outputs the period as o_nb_P, the counter's period input.
- Outputs o_lock, which drives the counter's run/enable input. The counter runs only while the estimate is trusted.

Parameters:
- W, 6, width of the period and interval counters; matches the 6-bit period bus.
- MIN_P, 4, intervals shorter than this many samples are glitches and are rejected.
- N_EDGES, 8, accepted edges per estimation window.
- TOL, 1, maximum allowed |new window min − current o_nb_P| to stay locked.
- DEFAULT_P, 16, o_nb_P value after reset.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous reset, active-high.
- i_valid  in  1  sample strobe; all state advances only when high.
- i_data  in  1  sliced chip sample (sign bit).
- o_nb_P  out  W  estimated chip period in samples.
- o_lock  out  1  estimate valid; feeds the counter's enable.
- o_edge  out  1  one-cycle pulse per accepted edge.

Behaviour:
- Reset: i_rst and i_clk as stated above (synchronous, active-high).
  - o_nb_P=DEFAULT_P, o_lock=0, o_edge=0.
  - State IDLE, counters 0, d_q=0.
  - primed=0: d_q not yet loaded since reset or since IDLE entry.
  - Reset mid-operation aborts any window immediately.
- Edge detect:
  - On each i_valid: d_q<=i_data; primed<=1.
  - edge = i_valid & primed & (i_data != d_q).
- Interval counter cnt (W bits):
  - Increments on each i_valid with no accepted edge.
  - Saturates at 2^W−1.
  - Set to 1 on an accepted edge.
  - Interval L = cnt value at the edge.
- Edge acceptance:
  - In ACQ/LOCK, an edge with L < MIN_P is rejected.
  - Rejected edge: cnt is not reset, o_edge stays low, window untouched. d_q still updates.
- States:
  - IDLE:
    - First edge → ACQ.
    - cnt=1, window cleared, no interval recorded.
  - ACQ:
    - Each accepted edge: win_min<=min(win_min, L); ecnt++.
    - win_min is initialised to all-ones at each window start.
    - When ecnt reaches N_EDGES: o_nb_P<=win_min, o_lock<=1, → LOCK, window cleared.
  - LOCK:
    - Same window accumulation.
    - At window end, if |win_min−o_nb_P| ≤ TOL: o_nb_P updated (see Optional Feature), stay.
    - Otherwise: o_lock<=0, o_nb_P unchanged, → ACQ, new window.
  - Timeout:
    - In ACQ or LOCK, cnt reaching 2^W−1 sends the block to IDLE.
    - o_lock<=0, primed<=0, o_nb_P retained.
    - The saturated value is never used as an interval.
- Latency: all outputs registered. o_edge, o_lock and o_nb_P change on the clock edge that samples the triggering i_valid beat.
- i_valid low: all state holds; o_edge=0.
- Window end and timeout cannot coincide, because an accepted edge clears cnt.

Optional Feature:
- Macro: CDR_PERIOD_SMOOTH_EN.
- Defined: in LOCK, a within-tolerance window end updates o_nb_P <= (o_nb_P + win_min + 1) >> 1. Computed in W+1 bits, so there is no overflow.
- Undefined: o_nb_P <= win_min directly.
- ACQ→LOCK always loads win_min directly, with or without the macro.

Decomposition:
- Package cdr_pkg:
  - cdr_state_t enum {IDLE, ACQ, LOCK}.
  - localparam CDR_P_W=6.
  - Shared by this block and the sample-point counter.
- Sub-module cdr_edge_detect:
  - Contains d_q, primed and the edge output.
  - Reusable by other CDR stages.

Test Plan:
- Lock: TOL=1, reset, i_valid=1, square wave toggling every 10 samples.
  - Expect o_lock=1 on the 9th edge (1 start + 8 accepted), o_nb_P=10.
  - Expect o_edge pulses on every accepted edge.
- Long run and glitch: while locked at 10, insert one 20-sample run and a 2-sample glitch.
  - Expect o_nb_P stays 10 and o_lock stays 1.
  - Glitch edges produce no o_edge and do not reset cnt.
- Period step: TOL=1, locked at 10, switch to toggling every 14.
  - At window end, expect o_lock→0.
  - Then relock after 8 more edges with o_nb_P=14.
- Timeout: locked, then hold i_data constant for 63 valid samples.
  - Expect IDLE, o_lock=0, o_nb_P=10 retained.
  - The next edge starts ACQ without recording an interval.
- i_valid gaps and reset: toggling every 10 valid samples with i_valid=0 on alternate cycles → o_nb_P=10 still. Assert i_rst mid-window → o_lock=0, o_nb_P=16 the next cycle.
- Smoothing: TOL=2, locked at 10, switch to period 12.
  - With CDR_PERIOD_SMOOTH_EN: o_nb_P=11 after the first window, 12 after the second.
  - Without the macro: o_nb_P=12 after the first window.
